// File: rtl/dmem_responder_if.sv
// Core-to-data-RAM request/response channel: one request in flight, valid/ready on both halves.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with byte strobes; response valid LATENCY+1 cycles after accept.
// Response held indefinitely under rsp_ready backpressure; req_ready only while idle.
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic            err_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     off;
  logic            addr_err;
  logic            wait_done;
  logic            commit;

  always_comb begin
    off       = bus.req_addr - ADDR_BASE;
    addr_err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < ADDR_BASE) ||
                ((off >> 2) >= 32'(DEPTH));
    // The wait window always spans LATENCY+1 edges so the response lands at accept+1+LATENCY.
    wait_done = (state == S_WAIT) && (cnt == 4'(LATENCY));
    commit    = wait_done && we_q && !err_q;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      idx_q         <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            err_q         <= addr_err;
            wdata_q       <= bus.req_wdata;
            wstrb_q       <= bus.req_wstrb;
            idx_q         <= off[AW+1:2];
            cnt           <= 4'd0;
            bus.req_ready <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            // Read-before-write is safe: loads never commit, stores return zero.
            bus.rsp_rdata <= (we_q || err_q) ? 32'd0 : mem[idx_q];
            bus.rsp_err   <= err_q;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard of expected responses and a RAM model.
module tb_dmem_responder;
  localparam int          DEPTH     = 1024;
  localparam int          LATENCY   = 2;
  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [31:0] model [int];

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_BASE(ADDR_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] addr);
    logic [31:0] o;
    o = addr - ADDR_BASE;
    return (addr[1:0] != 2'b00) || (addr < ADDR_BASE) || ((o >> 2) >= 32'(DEPTH));
  endfunction

  // One full transaction: predict, drive, wait bounded, compare, optional backpressure, handshake.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
    exp_t        e;
    exp_t        got;
    int          idx;
    int          n;
    int          lat;
    logic [31:0] w;
    logic [31:0] snap;
    idx     = int'((addr - ADDR_BASE) >> 2);
    e.err   = is_err(addr);
    e.rdata = 32'd0;
    if (!e.err) begin
      w = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
      if (!we) e.rdata = w;
      else begin
        for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model[idx] = w;
      end
    end
    sb.push_back(e);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    bus.rsp_ready = (hold == 0);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_wait"}, 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs after accept: the responder must have latched them.
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 32'h0000_0040;
    bus.req_wdata = 32'h5A5A_5A5A;
    bus.req_wstrb = 4'hF;
    chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LATENCY + 1));
    got = sb.pop_front();
    chk({tag, "_rdata"}, bus.rsp_rdata, got.rdata);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(got.err));
    snap = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, bus.rsp_rdata, snap);
      chk({tag, "_hold_busy"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_done_rdata_kept"}, bus.rsp_rdata, snap);
    bus.rsp_ready = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_wstrb = 4'd0;
  endtask

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_wstrb = 4'd0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_low_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_low_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);

    // Full-word store then load
    do_req("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    do_req("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("ld10_const", bus.rsp_rdata, 32'hDEAD_BEEF);

    // Byte strobes
    do_req("st20", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
    do_req("st20s", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
    do_req("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("ld20_const", bus.rsp_rdata, 32'h11BB_33DD);
    do_req("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0);
    do_req("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Errors: misaligned, past the end, erroneous store must not write
    do_req("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 0);
    do_req("ldend", 1'b0, ADDR_BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 0);
    do_req("st12", 1'b1, 32'h12, 32'h0BAD_0BAD, 4'hF, 0);
    do_req("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Backpressure for 5 cycles, then an immediate follow-up request
    do_req("bp", 1'b0, 32'h20, 32'h0, 4'h0, 5);
    do_req("bp_next", 1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Reset during the wait window of a store
    do_req("st30", 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstw_busy", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n++;
    end
    chk("rstw_no_rsp", 32'(n), 32'd0);
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    do_req("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0);
    chk("ld30_const", bus.rsp_rdata, 32'h0BAD_F00D);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
